// File: rtl/camera_capture_if.sv
// Framebuffer write port: a single-cycle strobe carrying one luma pixel
// and its destination coordinates. The capture block drives it (master),
// the framebuffer consumes it (slave).
interface camera_capture_if;
  logic        write_enable;
  logic [7:0]  data_in;
  logic [10:0] data_in_x;
  logic [10:0] data_in_y;

  modport master (
    output write_enable,
    output data_in,
    output data_in_x,
    output data_in_y
  );

  modport slave (
    input write_enable,
    input data_in,
    input data_in_x,
    input data_in_y
  );
endinterface

// File: rtl/camera_capture.sv
// Camera capture front end: turns the synchronised YUV422 byte stream into
// decimated luma pixel writes for the 320x240 framebuffer. Frames are armed
// by capture_enable while vsync is high and captured between vsync falling
// and the next vsync rising.
module camera_capture #(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int DECIM      = 2,
  parameter int Y_PHASE    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture_enable,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_data,
  camera_capture_if.master  fb,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [10:0] X_LIMIT = 11'(SRC_WIDTH);
  localparam logic [10:0] Y_LIMIT = 11'(SRC_HEIGHT);
  localparam logic [10:0] SAT     = 11'h7FF;
  localparam logic        HALVE   = (DECIM == 2);
  localparam logic        Y_SLOT  = (Y_PHASE != 0);

  state_t      state;
  state_t      state_next;
  logic        pclk_q;
  logic        href_q;
  logic [10:0] src_x;
  logic [10:0] src_y;
  logic        byte_phase;

  logic        pclk_rise;
  logic        href_fall;
  logic        capturing;
  logic        sample;
  logic        is_luma;
  logic        in_range;
  logic        on_grid;
  logic        write_hit;
  logic        frame_end;

  // Byte strobes and the write qualification for the current cycle; vsync
  // takes priority so nothing is captured on the cycle the frame closes.
  always_comb begin
    pclk_rise = cam_pclk & ~pclk_q;
    href_fall = href_q & ~cam_href;
    capturing = (state == ACTIVE) && !cam_vsync;
    sample    = capturing && pclk_rise && cam_href;
    is_luma   = (byte_phase == Y_SLOT);
    in_range  = (src_x < X_LIMIT) && (src_y < Y_LIMIT);
    on_grid   = !HALVE || (!src_x[0] && !src_y[0]);
    write_hit = sample && is_luma && in_range && on_grid;
    frame_end = (state == ACTIVE) && cam_vsync;
  end

  // Frame state: arm during vsync blanking, capture between vsync edges.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture_enable && cam_vsync) state_next = SYNC;
      SYNC:    if (!cam_vsync) state_next = ACTIVE;
      ACTIVE:  if (cam_vsync) state_next = capture_enable ? SYNC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Previous pclk/href levels for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      pclk_q <= 1'b0;
      href_q <= 1'b0;
    end else begin
      pclk_q <= cam_pclk;
      href_q <= cam_href;
    end
  end

  // Source position tracking; cleared while waiting for the frame to start.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_x      <= '0;
      src_y      <= '0;
      byte_phase <= 1'b0;
    end else if (state == SYNC) begin
      src_x      <= '0;
      src_y      <= '0;
      byte_phase <= 1'b0;
    end else if (capturing && href_fall) begin
      src_x      <= '0;
      byte_phase <= 1'b0;
      if (src_y != SAT) src_y <= src_y + 11'd1;
    end else if (sample) begin
      byte_phase <= ~byte_phase;
      if (is_luma && src_x != SAT) src_x <= src_x + 11'd1;
    end
  end

  // Registered framebuffer write; coordinates and data hold between writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      fb.write_enable <= 1'b0;
      fb.data_in      <= '0;
      fb.data_in_x    <= '0;
      fb.data_in_y    <= '0;
    end else begin
      fb.write_enable <= write_hit;
      if (write_hit) begin
        fb.data_in   <= cam_data;
        fb.data_in_x <= HALVE ? (src_x >> 1) : src_x;
        fb.data_in_y <= HALVE ? (src_y >> 1) : src_y;
      end
    end
  end

  // End-of-frame pulse and completed frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + 8'd1;
    end
  end

  assign busy = (state == ACTIVE);

endmodule
